// File: rtl/spi_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_arbiter_if
//   Bundles the client-side toggle handshakes and the engine-side toggle
//   handshake of the SPI byte-engine arbiter.
//
//   Handshake (all toggle based, both directions):
//     A requester flips its req line to ask for one byte.  A byte is
//     pending while req != ack.  The responder flips ack (to equal req)
//     exactly once when the byte is done, in the same cycle it presents the
//     result.  The requester must not flip req again while pending.
//
//   Signals
//     client_req   [CLIENTS]    per-client request toggle
//     client_ack   [CLIENTS]    per-client ack toggle
//     client_d     [8*CLIENTS]  per-client MOSI byte, client i at [8i+7:8i]
//     client_speed [CLIENTS]    per-client speed select (1 = fast)
//     client_lock  [CLIENTS]    1 = client is inside a CS frame
//     client_q     [8]          last MISO byte, broadcast
//     spi_req/spi_ack           toggle handshake with the byte engine
//     spi_d/spi_speed/spi_q     byte engine data and speed
//     owner        [OWNER_W]    current or last granted client
//     busy                      engine transfer in flight
//
//   Modports
//     master : the arbiter itself
//     slave  : clients plus engine (environment side)
// ---------------------------------------------------------------------------
interface spi_arbiter_if #(
   parameter int CLIENTS = 3,
   parameter int OWNER_W = 3
);
   logic [CLIENTS-1:0]   client_req;
   logic [CLIENTS-1:0]   client_ack;
   logic [8*CLIENTS-1:0] client_d;
   logic [CLIENTS-1:0]   client_speed;
   logic [CLIENTS-1:0]   client_lock;
   logic [7:0]           client_q;
   logic                 spi_req;
   logic                 spi_ack;
   logic [7:0]           spi_d;
   logic                 spi_speed;
   logic [7:0]           spi_q;
   logic [OWNER_W-1:0]   owner;
   logic                 busy;

   modport master (
      input  client_req, client_d, client_speed, client_lock, spi_ack, spi_q,
      output client_ack, client_q, spi_req, spi_d, spi_speed, owner, busy
   );

   modport slave (
      output client_req, client_d, client_speed, client_lock, spi_ack, spi_q,
      input  client_ack, client_q, spi_req, spi_d, spi_speed, owner, busy
   );
endinterface

// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//   Shares one chameleon2_spi byte engine between several clients (index 0 =
//   NOR flash loader, 1 = MMC64, further indices for later clients).  One
//   byte is granted at a time, round-robin starting after the last owner.
//   A client that holds client_lock while it owns the engine keeps exclusive
//   ownership so a multi-byte chip-select frame is not interleaved.
//
//   Parameters
//     CLIENTS  number of requesters, 2..8
//     OWNER_W  owner index width, 2**OWNER_W >= CLIENTS
//
//   Ports
//     clk        system clock
//     reset_n    asynchronous reset, active low
//     bus        spi_arbiter_if.master: client and engine handshakes
//     dbg_state  current FSM state (0 = SYNC, 1 = IDLE, 2 = WAIT)
//
//   Flow
//     SYNC : align spi_req to spi_ack so an engine that kept running through
//            our reset cannot look like a completed byte.
//     IDLE : pick a pending client, latch its byte/speed, toggle spi_req.
//     WAIT : on spi_ack == spi_req, broadcast spi_q, toggle the owner's ack.
//   Cost per byte is two clocks beyond the engine time (grant + completion).
// ---------------------------------------------------------------------------
module spi_arbiter #(
   parameter int CLIENTS = 3,
   parameter int OWNER_W = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   spi_arbiter_if.master bus,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CLIENTS-1:0]   ack_q, ack_d;
   logic [7:0]           cq_q, cq_d;
   logic                 spi_req_q, spi_req_d;
   logic [7:0]           spi_d_q, spi_d_d;
   logic                 spi_speed_q, spi_speed_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic                 busy_q, busy_d;

   // A byte is outstanding for client i while its toggles disagree.
   logic [CLIENTS-1:0]   pend;
   assign pend = bus.client_req ^ ack_q;

   // ------------------------------------------------------------------
   // Lock and pending state of the current owner.  Done with a compare
   // loop so the owner index never addresses beyond CLIENTS-1.
   // ------------------------------------------------------------------
   logic owner_locked;
   logic owner_pend;

   always_comb begin
      owner_locked = 1'b0;
      owner_pend   = 1'b0;
      for (int j = 0; j < CLIENTS; j++) begin
         if (owner_q == OWNER_W'(j)) begin
            owner_locked = bus.client_lock[j];
            owner_pend   = pend[j];
         end
      end
   end

   // ------------------------------------------------------------------
   // Grant selection.
   //   Locked owner: only the owner may be served, others wait.
   //   Otherwise: scan owner+1, owner+2, ... wrapping at CLIENTS, ending
   //   at the owner itself.  The scan runs from the farthest candidate to
   //   the nearest so the last hit written is the nearest one.
   // ------------------------------------------------------------------
   logic               grant_valid;
   logic [OWNER_W-1:0] grant_idx;
   int                 cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = owner_q;
      cand        = 0;
      if (owner_locked) begin
         grant_valid = owner_pend;
         grant_idx   = owner_q;
      end else begin
         for (int k = CLIENTS; k >= 1; k--) begin
            cand = int'(owner_q) + k;
            // owner_q < CLIENTS and k <= CLIENTS, so one wrap suffices
            if (cand >= CLIENTS) begin
               cand = cand - CLIENTS;
            end
            for (int j = 0; j < CLIENTS; j++) begin
               if ((cand == j) && pend[j]) begin
                  grant_valid = 1'b1;
                  grant_idx   = OWNER_W'(j);
               end
            end
         end
      end
   end

   // Byte and speed of the selected client.
   logic [7:0] grant_d;
   logic       grant_speed;

   always_comb begin
      grant_d     = 8'h00;
      grant_speed = 1'b0;
      for (int j = 0; j < CLIENTS; j++) begin
         if (grant_idx == OWNER_W'(j)) begin
            grant_d     = bus.client_d[8*j +: 8];
            grant_speed = bus.client_speed[j];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic.  All outputs are registered; spi_d/spi_speed are
   // only loaded on a grant, so they stay stable for the whole of WAIT
   // whatever the client does with its inputs meanwhile.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ack_d       = ack_q;
      cq_d        = cq_q;
      spi_req_d   = spi_req_q;
      spi_d_d     = spi_d_q;
      spi_speed_d = spi_speed_q;
      owner_d     = owner_q;
      busy_d      = busy_q;

      case (state_q)
         ST_SYNC: begin
            // Absorb whatever toggle state the engine is in.
            spi_req_d = bus.spi_ack;
            state_d   = ST_IDLE;
         end

         ST_IDLE: begin
            if (grant_valid) begin
               owner_d     = grant_idx;
               spi_d_d     = grant_d;
               spi_speed_d = grant_speed;
               spi_req_d   = ~spi_req_q;
               busy_d      = 1'b1;
               state_d     = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (bus.spi_ack == spi_req_q) begin
               cq_d   = bus.spi_q;
               busy_d = 1'b0;
               // Ack and client_q change together, so a client that sees
               // req == ack can read client_q in the same cycle.
               for (int j = 0; j < CLIENTS; j++) begin
                  if (owner_q == OWNER_W'(j)) begin
                     ack_d[j] = ~ack_q[j];
                  end
               end
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_SYNC;
         ack_q       <= '0;
         cq_q        <= 8'h00;
         spi_req_q   <= 1'b0;
         spi_d_q     <= 8'h00;
         spi_speed_q <= 1'b0;
         owner_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         cq_q        <= cq_d;
         spi_req_q   <= spi_req_d;
         spi_d_q     <= spi_d_d;
         spi_speed_q <= spi_speed_d;
         owner_q     <= owner_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.client_ack = ack_q;
   assign bus.client_q   = cq_q;
   assign bus.spi_req    = spi_req_q;
   assign bus.spi_d      = spi_d_q;
   assign bus.spi_speed  = spi_speed_q;
   assign bus.owner      = owner_q;
   assign bus.busy       = busy_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_arbiter
//   Directed bench for spi_arbiter with CLIENTS=3.  Stimulus pushes the
//   expected grants ({owner, speed, byte}) and completions ({client, q})
//   into queues; a monitor pops and compares whenever the arbiter issues a
//   grant or toggles a client ack.  A small engine model answers each
//   spi_req toggle after a fixed delay with a byte from its own queue.
// ---------------------------------------------------------------------------
module tb_spi_arbiter;

   localparam int CLIENTS   = 3;
   localparam int OWNER_W   = 3;
   localparam int ENG_DELAY = 2;
   localparam int BUDGET    = 300;

   localparam logic [1:0] ST_SYNC = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       reset_n;
   logic [1:0] dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   spi_arbiter_if #(.CLIENTS(CLIENTS), .OWNER_W(OWNER_W)) bus ();

   spi_arbiter #(.CLIENTS(CLIENTS), .OWNER_W(OWNER_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [11:0] exp_grant_q[$];
   logic [10:0] exp_done_q[$];
   logic [7:0]  eng_data_q[$];
   logic        engine_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   task automatic exp_byte(input int i, input logic [7:0] d, input logic sp, input logic [7:0] q);
      exp_grant_q.push_back({3'(i), sp, d});
      exp_done_q.push_back({3'(i), q});
      eng_data_q.push_back(q);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_ready(input int i);
      int n;
      n = 0;
      @(negedge clk);
      while ((bus.client_req[i] != bus.client_ack[i]) && (n < BUDGET)) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) fail_now("wait_ready_timeout", 32'(i));
   endtask

   task automatic send(input int i, input logic [7:0] d, input logic sp);
      wait_ready(i);
      bus.client_d[8*i +: 8] = d;
      bus.client_speed[i]    = sp;
      bus.client_req[i]      = ~bus.client_req[i];
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_grant_q.size() != 0 || exp_done_q.size() != 0 || bus.busy) && (n < BUDGET)) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) fail_now(name, 32'(exp_done_q.size()));
      @(negedge clk);
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      while ((exp_grant_q.size() != 0) && (n < BUDGET)) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) fail_now(name, 32'(exp_grant_q.size()));
   endtask

   // ---------------- engine model ----------------
   int eng_cnt;
   initial begin
      eng_cnt = 0;
      forever begin
         @(negedge clk);
         if (engine_en && reset_n && (bus.spi_req != bus.spi_ack)) begin
            if (eng_cnt >= ENG_DELAY) begin
               bus.spi_q   = (eng_data_q.size() != 0) ? eng_data_q.pop_front() : 8'h00;
               bus.spi_ack = ~bus.spi_ack;
               eng_cnt     = 0;
            end else begin
               eng_cnt++;
            end
         end else begin
            eng_cnt = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic               prev_req;
      logic               prev_busy;
      logic [CLIENTS-1:0] prev_ack;
      logic [CLIENTS-1:0] diff;
      logic [7:0]         held_d;
      logic               held_sp;
      logic [11:0]        eg;
      logic [10:0]        ed;
      int                 idx;
      prev_req  = 1'b0;
      prev_busy = 1'b0;
      prev_ack  = '0;
      held_d    = 8'h00;
      held_sp   = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_req  = bus.spi_req;
            prev_ack  = bus.client_ack;
            prev_busy = 1'b0;
         end else begin
            if ((bus.spi_req != prev_req) && bus.busy) begin
               held_d  = bus.spi_d;
               held_sp = bus.spi_speed;
               if (exp_grant_q.size() == 0) begin
                  fail_now("unexpected_grant", {bus.owner, bus.spi_speed, bus.spi_d});
               end else begin
                  eg = exp_grant_q.pop_front();
                  check("grant", {20'h0, bus.owner, bus.spi_speed, bus.spi_d}, {20'h0, eg});
               end
            end else if (bus.busy && prev_busy) begin
               check("spi_d_stable", {bus.spi_speed, bus.spi_d}, {held_sp, held_d});
            end
            diff = bus.client_ack ^ prev_ack;
            if (diff != '0) begin
               idx = 0;
               for (int j = 0; j < CLIENTS; j++) if (diff[j]) idx = j;
               if ($countones(diff) != 1) begin
                  fail_now("multi_ack", 32'(diff));
               end else if (exp_done_q.size() == 0) begin
                  fail_now("unexpected_ack", 32'(idx));
               end else begin
                  ed = exp_done_q.pop_front();
                  check("done", {21'h0, 3'(idx), bus.client_q}, {21'h0, ed});
                  check("done_busy", 32'(bus.busy), 32'd0);
               end
            end
            prev_req  = bus.spi_req;
            prev_ack  = bus.client_ack;
            prev_busy = bus.busy;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_n          = 1'b0;
      engine_en        = 1'b1;
      bus.client_req   = '0;
      bus.client_d     = '0;
      bus.client_speed = '0;
      bus.client_lock  = '0;
      bus.spi_ack      = 1'b0;
      bus.spi_q        = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_client_ack", 32'(bus.client_ack), 32'd0);
      check("rst_spi_req", 32'(bus.spi_req), 32'd0);
      check("rst_spi_d", 32'(bus.spi_d), 32'd0);
      check("rst_owner", 32'(bus.owner), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_client_q", 32'(bus.client_q), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_SYNC));
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("sync_to_idle", 32'(dbg_state), 32'(ST_IDLE));

      // Test 1: single byte from client 1, 1 clk grant latency
      exp_byte(1, 8'h5A, 1'b1, 8'hC3);
      send(1, 8'h5A, 1'b1);
      @(posedge clk); #1;
      check("t1_spi_req", 32'(bus.spi_req), 32'd1);
      check("t1_spi_d", 32'(bus.spi_d), 32'h5A);
      check("t1_spi_speed", 32'(bus.spi_speed), 32'd1);
      check("t1_owner", 32'(bus.owner), 32'd1);
      check("t1_busy", 32'(bus.busy), 32'd1);
      wait_idle("t1_timeout");
      check("t1_client_q", 32'(bus.client_q), 32'hC3);
      check("t1_client_ack", 32'(bus.client_ack), 32'b010);

      // Move ownership to client 0
      exp_byte(0, 8'h11, 1'b0, 8'h22);
      send(0, 8'h11, 1'b0);
      wait_idle("t2_prep_timeout");
      check("t2_owner0", 32'(bus.owner), 32'd0);

      // Test 2: all three pending at once from owner 0 -> 1, 2, 0
      exp_byte(1, 8'hA1, 1'b0, 8'hB1);
      exp_byte(2, 8'hA2, 1'b1, 8'hB2);
      exp_byte(0, 8'hA0, 1'b0, 8'hB0);
      @(negedge clk);
      bus.client_d     = {8'hA2, 8'hA1, 8'hA0};
      bus.client_speed = 3'b100;
      bus.client_req   = bus.client_req ^ 3'b111;
      wait_idle("t2_timeout");
      check("t2_all_acked", 32'(bus.client_ack), 32'(bus.client_req));

      // Test 3: client 1 locked for 4 bytes, client 0 pending throughout
      for (int k = 0; k < 4; k++) exp_byte(1, 8'hC0 + 8'(k), 1'b0, 8'h40 + 8'(k));
      exp_byte(0, 8'hE0, 1'b0, 8'h50);
      @(negedge clk);
      bus.client_lock      = 3'b010;
      bus.client_speed     = 3'b000;
      bus.client_d[7:0]    = 8'hE0;
      bus.client_d[15:8]   = 8'hC0;
      bus.client_req       = bus.client_req ^ 3'b011;
      for (int k = 1; k < 4; k++) begin
         wait_ready(1);
         bus.client_d[15:8] = 8'hC0 + 8'(k);
         bus.client_req[1]  = ~bus.client_req[1];
      end
      wait_ready(1);
      check("t3_client0_waiting", 32'(bus.client_req[0] ^ bus.client_ack[0]), 32'd1);
      bus.client_lock = 3'b000;
      @(posedge clk); #1;
      check("t3_unlock_owner", 32'(bus.owner), 32'd0);
      check("t3_unlock_busy", 32'(bus.busy), 32'd1);
      wait_idle("t3_timeout");

      // Test 6: client_d changes mid-WAIT
      exp_byte(2, 8'h33, 1'b1, 8'h66);
      send(2, 8'h33, 1'b1);
      @(posedge clk); #1;
      check("t6_owner", 32'(bus.owner), 32'd2);
      @(negedge clk);
      bus.client_d[23:16] = 8'h44;
      bus.client_speed[2] = 1'b0;
      @(negedge clk);
      check("t6_busy", 32'(bus.busy), 32'd1);
      check("t6_spi_d_held", 32'(bus.spi_d), 32'h33);
      check("t6_spi_speed_held", 32'(bus.spi_speed), 32'd1);
      wait_idle("t6_timeout");
      exp_byte(2, 8'h44, 1'b0, 8'h77);
      send(2, 8'h44, 1'b0);
      wait_idle("t6b_timeout");

      // Test 5: owner 2, only client 0 pending -> wrap to 0
      exp_byte(0, 8'h5C, 1'b1, 8'hE5);
      send(0, 8'h5C, 1'b1);
      @(posedge clk); #1;
      check("t5_owner_wrap", 32'(bus.owner), 32'd0);
      check("t5_busy", 32'(bus.busy), 32'd1);
      wait_idle("t5_timeout");
      check("t5_client_q", 32'(bus.client_q), 32'hE5);

      // Test 4: stale engine (spi_ack stays 1), reset while in WAIT.
      // 13 grants so far leave spi_req = spi_ack = 1; the 14th drives 0.
      engine_en = 1'b0;
      exp_grant_q.push_back({3'd2, 1'b0, 8'h99});
      send(2, 8'h99, 1'b0);
      wait_grant("t4_grant_timeout");
      check("t4_wait_state", 32'(dbg_state), 32'(ST_WAIT));
      check("t4_spi_req_wait", 32'(bus.spi_req), 32'd0);
      repeat (2) @(negedge clk);
      reset_n        = 1'b0;
      bus.client_req = '0;
      #1;
      check("t4_rst_spi_req", 32'(bus.spi_req), 32'd0);
      check("t4_rst_busy", 32'(bus.busy), 32'd0);
      check("t4_rst_owner", 32'(bus.owner), 32'd0);
      check("t4_rst_spi_d", 32'(bus.spi_d), 32'd0);
      check("t4_rst_state", 32'(dbg_state), 32'(ST_SYNC));
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("t4_sync_spi_req", 32'(bus.spi_req), 32'd1);
      check("t4_sync_ack", 32'(bus.client_ack), 32'd0);
      check("t4_sync_idle", 32'(dbg_state), 32'(ST_IDLE));
      exp_byte(1, 8'h77, 1'b0, 8'h88);
      send(1, 8'h77, 1'b0);
      @(posedge clk); #1;
      check("t4_next_spi_req", 32'(bus.spi_req), 32'd0);
      check("t4_next_owner", 32'(bus.owner), 32'd1);
      @(negedge clk);
      engine_en = 1'b1;
      wait_idle("t4_timeout");
      check("t4_client_q", 32'(bus.client_q), 32'h88);
      check("t4_client_ack", 32'(bus.client_ack), 32'b010);

      // Final report
      repeat (4) @(negedge clk);
      check("queues_empty", 32'(exp_grant_q.size() + exp_done_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
